// File: rtl/ibex_id_seq_if.sv
// Bundle between the ID-stage sequencer and its decoder, controller and execute units.
// The master side drives decoder flags and unit responses; the slave side is the sequencer.
interface ibex_id_seq_if #(
   parameter int unsigned CntWidth = 16
) ();

   logic                instr_valid_i;
   logic                flush_id_i;
   logic                illegal_insn_i;
   logic                data_req_dec_i;
   logic                mult_en_dec_i;
   logic                div_en_dec_i;
   logic                alu_multicycle_dec_i;
   logic                jump_in_dec_i;
   logic                branch_in_dec_i;
   logic                branch_taken_i;
   logic                lsu_resp_valid_i;
   logic                multdiv_ready_i;

   logic                instr_first_cycle_o;
   logic                lsu_req_o;
   logic                multdiv_en_o;
   logic                jump_set_o;
   logic                branch_set_o;
   logic                stall_o;
   logic                instr_done_o;
   logic                busy_o;
   logic [CntWidth-1:0] instr_cnt_o;
   logic [CntWidth-1:0] stall_cnt_o;

   modport master (
      output instr_valid_i, flush_id_i, illegal_insn_i,
             data_req_dec_i, mult_en_dec_i, div_en_dec_i, alu_multicycle_dec_i,
             jump_in_dec_i, branch_in_dec_i, branch_taken_i,
             lsu_resp_valid_i, multdiv_ready_i,
      input  instr_first_cycle_o, lsu_req_o, multdiv_en_o, jump_set_o, branch_set_o,
             stall_o, instr_done_o, busy_o, instr_cnt_o, stall_cnt_o
   );

   modport slave (
      input  instr_valid_i, flush_id_i, illegal_insn_i,
             data_req_dec_i, mult_en_dec_i, div_en_dec_i, alu_multicycle_dec_i,
             jump_in_dec_i, branch_in_dec_i, branch_taken_i,
             lsu_resp_valid_i, multdiv_ready_i,
      output instr_first_cycle_o, lsu_req_o, multdiv_en_o, jump_set_o, branch_set_o,
             stall_o, instr_done_o, busy_o, instr_cnt_o, stall_cnt_o
   );

endinterface

// File: rtl/ibex_id_seq.sv
// ID-stage instruction sequencer: steps each decoded instruction through one or more
// cycles, issues first-cycle strobes, stalls IF-ID until completion, counts retires/stalls.
module ibex_id_seq #(
   parameter bit          BranchTargetALU = 1'b0,
   parameter int unsigned CntWidth        = 16
) (
   input logic          clk_i,
   input logic          rst_ni,
   ibex_id_seq_if.slave bus
);

   typedef enum logic {
      FIRST_CYCLE = 1'b0,
      MULTI_CYCLE = 1'b1
   } state_e;

   typedef enum logic [2:0] {
      CLS_NONE   = 3'd0,
      CLS_LSU    = 3'd1,
      CLS_MD     = 3'd2,
      CLS_ALU2   = 3'd3,
      CLS_JUMP   = 3'd4,
      CLS_BRANCH = 3'd5
   } cls_e;

   localparam logic [CntWidth-1:0] CntMax = {CntWidth{1'b1}};

   state_e              state_q, state_d;
   cls_e                cls_q, cls_d, cls_dec;
   logic [CntWidth-1:0] instr_cnt_q, instr_cnt_d;
   logic [CntWidth-1:0] stall_cnt_q, stall_cnt_d;
   logic                lsu_req, multdiv_en, jump_set, branch_set, instr_done, stall;

   // Fixed priority when the decoder raises several class flags at once.
   always_comb begin
      cls_dec = CLS_NONE;
      if (bus.data_req_dec_i) begin
         cls_dec = CLS_LSU;
      end else if (bus.mult_en_dec_i || bus.div_en_dec_i) begin
         cls_dec = CLS_MD;
      end else if (bus.alu_multicycle_dec_i) begin
         cls_dec = CLS_ALU2;
      end else if (bus.jump_in_dec_i) begin
         cls_dec = CLS_JUMP;
      end else if (bus.branch_in_dec_i) begin
         cls_dec = CLS_BRANCH;
      end
   end

   always_comb begin
      state_d    = state_q;
      cls_d      = cls_q;
      lsu_req    = 1'b0;
      multdiv_en = 1'b0;
      jump_set   = 1'b0;
      branch_set = 1'b0;
      instr_done = 1'b0;

      if (bus.flush_id_i) begin
         state_d = FIRST_CYCLE;
         cls_d   = CLS_NONE;
      end else begin
         case (state_q)
            FIRST_CYCLE: begin
               if (bus.instr_valid_i) begin
                  if (bus.illegal_insn_i) begin
                     instr_done = 1'b1;
                  end else begin
                     case (cls_dec)
                        CLS_LSU: begin
                           lsu_req = 1'b1;
                           if (bus.lsu_resp_valid_i) begin
                              instr_done = 1'b1;
                           end else begin
                              state_d = MULTI_CYCLE;
                              cls_d   = CLS_LSU;
                           end
                        end
                        CLS_MD: begin
                           multdiv_en = 1'b1;
                           if (bus.multdiv_ready_i) begin
                              instr_done = 1'b1;
                           end else begin
                              state_d = MULTI_CYCLE;
                              cls_d   = CLS_MD;
                           end
                        end
                        CLS_ALU2: begin
                           state_d = MULTI_CYCLE;
                           cls_d   = CLS_ALU2;
                        end
                        CLS_JUMP: begin
                           jump_set = 1'b1;
                           if (BranchTargetALU) begin
                              instr_done = 1'b1;
                           end else begin
                              state_d = MULTI_CYCLE;
                              cls_d   = CLS_JUMP;
                           end
                        end
                        CLS_BRANCH: begin
                           branch_set = bus.branch_taken_i;
                           if (!bus.branch_taken_i || BranchTargetALU) begin
                              instr_done = 1'b1;
                           end else begin
                              state_d = MULTI_CYCLE;
                              cls_d   = CLS_BRANCH;
                           end
                        end
                        default: instr_done = 1'b1;
                     endcase
                  end
               end
            end
            MULTI_CYCLE: begin
               case (cls_q)
                  CLS_LSU: instr_done = bus.lsu_resp_valid_i;
                  CLS_MD: begin
                     multdiv_en = 1'b1;
                     instr_done = bus.multdiv_ready_i;
                  end
                  default: instr_done = 1'b1;
               endcase
               if (instr_done) begin
                  state_d = FIRST_CYCLE;
                  cls_d   = CLS_NONE;
               end
            end
            default: begin
               state_d = FIRST_CYCLE;
               cls_d   = CLS_NONE;
            end
         endcase
      end
   end

   assign stall = bus.instr_valid_i & ~instr_done & ~bus.flush_id_i;

   // Counters saturate rather than wrap so a long run never reports a small value.
   always_comb begin
      instr_cnt_d = instr_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (instr_done && !bus.illegal_insn_i && instr_cnt_q != CntMax) begin
         instr_cnt_d = instr_cnt_q + CntWidth'(1);
      end
      if (stall && stall_cnt_q != CntMax) begin
         stall_cnt_d = stall_cnt_q + CntWidth'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= FIRST_CYCLE;
         cls_q       <= CLS_NONE;
         instr_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cls_q       <= cls_d;
         instr_cnt_q <= instr_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.instr_first_cycle_o = bus.instr_valid_i & (state_q == FIRST_CYCLE);
   assign bus.lsu_req_o           = lsu_req;
   assign bus.multdiv_en_o        = multdiv_en;
   assign bus.jump_set_o          = jump_set;
   assign bus.branch_set_o        = branch_set;
   assign bus.stall_o             = stall;
   assign bus.instr_done_o        = instr_done;
   assign bus.busy_o              = (state_q == MULTI_CYCLE);
   assign bus.instr_cnt_o         = instr_cnt_q;
   assign bus.stall_cnt_o         = stall_cnt_q;

   // Upstream must keep the instruction valid until a multi-cycle sequence completes.
   valid_held_in_multi: assert property (
      @(posedge clk_i) disable iff (!rst_ni) (state_q == MULTI_CYCLE) |-> bus.instr_valid_i
   );

endmodule

// File: doc/ibex_id_seq.md
# ibex_id_seq

Instruction-sequencing controller for the ID stage. It sits between the instruction decoder and the execute resources (ALU, LSU, multiplier/divider, branch unit) and steps each decoded instruction through one or more ID cycles. It issues first-cycle strobes and holds the IF-ID register with a stall until the instruction's resource reports completion. It also keeps saturating performance counters of retired instructions and stall cycles.

## Interface
- BranchTargetALU, 0: 1 = a dedicated branch-target adder exists, so taken branches and jumps complete in one cycle; 0 = each needs one extra cycle.
- CntWidth, 16: width of the performance counters, 8..32.

- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- instr_valid_i  in  1  IF-ID register holds a valid instruction
- flush_id_i  in  1  controller kills the ID instruction
- illegal_insn_i  in  1  decoder flagged the instruction illegal
- data_req_dec_i, mult_en_dec_i, div_en_dec_i, alu_multicycle_dec_i, jump_in_dec_i, branch_in_dec_i  in  1 each  decoder class flags
- branch_taken_i  in  1  branch condition result, valid in the first cycle
- lsu_resp_valid_i  in  1  LSU response or error returned
- multdiv_ready_i  in  1  multiplier/divider result valid
- instr_first_cycle_o  out  1  instruction is in its first ID cycle
- lsu_req_o  out  1  one-cycle LSU start strobe
- multdiv_en_o  out  1  multdiv enable, held until ready
- jump_set_o, branch_set_o  out  1 each  PC redirect strobes to the controller
- stall_o  out  1  hold the IF-ID register
- instr_done_o  out  1  instruction completes this cycle
- busy_o  out  1  FSM in MULTI_CYCLE
- instr_cnt_o, stall_cnt_o  out  CntWidth each  saturating retire and stall counters

## Operation
- The FSM has two states, FIRST_CYCLE and MULTI_CYCLE, plus a registered class field: LSU, MD, ALU2, JUMP, BRANCH.
- An instruction is active when `instr_valid_i & ~illegal_insn_i & ~flush_id_i`.
- If more than one class flag is set, the fixed priority is: data_req > mult/div > alu_multicycle > jump > branch.
- FIRST_CYCLE, active instruction:
  - LSU: lsu_req_o=1. If lsu_resp_valid_i, the instruction is done. Otherwise go to MULTI_CYCLE(LSU).
  - MD: multdiv_en_o=1. If multdiv_ready_i, the instruction is done. Otherwise go to MULTI_CYCLE(MD).
  - ALU2: go to MULTI_CYCLE(ALU2).
  - JUMP: jump_set_o=1. If BranchTargetALU, the instruction is done. Otherwise go to MULTI_CYCLE(JUMP).
  - BRANCH: branch_set_o=branch_taken_i. If not taken or BranchTargetALU, the instruction is done. Otherwise go to MULTI_CYCLE(BRANCH).
  - No class flag set: the instruction is done.
- MULTI_CYCLE:
  - LSU: done when lsu_resp_valid_i.
  - MD: multdiv_en_o=1; done when multdiv_ready_i.
  - ALU2, JUMP, BRANCH: done unconditionally, so each takes exactly 2 cycles.
  - Every done transitions back to FIRST_CYCLE.
- An illegal instruction in FIRST_CYCLE is done immediately with no strobes; the controller takes the exception.
- Combinational outputs:
  - instr_first_cycle_o = instr_valid_i & (state==FIRST_CYCLE).
  - stall_o = instr_valid_i & ~instr_done_o & ~flush_id_i.
  - busy_o = (state==MULTI_CYCLE).
- Flush: flush_id_i forces all strobes, instr_done_o and stall_o to 0. The next state is FIRST_CYCLE and the class field is cleared. An LSU or multdiv response arriving after a flush is ignored.
- Counters:
  - instr_cnt increments on instr_done_o & ~illegal_insn_i.
  - stall_cnt increments on every cycle with stall_o=1.
  - Both saturate at all-ones and never wrap.

## Timing
- Reset:
  - state=FIRST_CYCLE, class field cleared, both counters 0.
  - With instr_valid_i=0, every combinational output is 0.
- Registered state and counters only; all other outputs are combinational from state and inputs, with no added latency.
- Latencies:
  - lsu_req_o, jump_set_o and branch_set_o each pulse exactly once per instruction, in its first cycle.
  - ALU-only instructions take 1 cycle.
  - ALU2 takes 2 cycles.
  - Taken branches and jumps take 2 cycles when BranchTargetALU=0.
  - LSU and MD take 1 + the number of wait cycles.
- A response in the same cycle as flush_id_i does not produce done.
- Reset asserted mid-instruction returns everything to reset values asynchronously.
- The counter value seen on a given cycle excludes that cycle's increment.
- instr_valid_i dropping in MULTI_CYCLE is illegal upstream. It is covered by an assertion only.

## Test plan
- Back-to-back 3 ALU instructions, valid held -> instr_done_o=1 for 3 consecutive cycles, stall_o=0 throughout, instr_cnt=3.
- Load, lsu_resp_valid_i 4 cycles after issue -> lsu_req_o pulses once in cycle 0, stall_o=1 for cycles 0-3, done in cycle 4, stall_cnt=4.
- Divide, multdiv_ready_i at cycle 36 -> multdiv_en_o high for cycles 0-36, done in cycle 36.
- Taken branch with BranchTargetALU=0 -> branch_set_o=1 in cycle 0, done in cycle 1. Repeat with BranchTargetALU=1 -> done in cycle 0. Not-taken branch -> done in cycle 0 with branch_set_o=0.
- Load, flush_id_i in MULTI_CYCLE with lsu_resp_valid_i in the same cycle -> no done, FIRST_CYCLE next cycle, instr_cnt unchanged.
- CntWidth=8, 300 stall cycles -> stall_cnt_o=255 and held. Reset asserted mid-stall -> counters read 0 and busy_o=0 immediately.
